// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: control codes, FSM states and code-class predicates.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SLL  = 5'b00001,
    ALU_SLT  = 5'b00010,
    ALU_SLTU = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SRL  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_AND  = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_SRA  = 5'b01101,
    ALU_BEQ  = 5'b10000,
    ALU_BNE  = 5'b10001,
    ALU_BLT  = 5'b10100,
    ALU_BGE  = 5'b10101,
    ALU_BLTU = 5'b10110,
    ALU_BGEU = 5'b10111,
    ALU_JAL  = 5'b11111
  } aluc_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [4:0] c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

  function automatic logic is_branch(input logic [4:0] c);
    return (c == ALU_BEQ) || (c == ALU_BNE) || (c == ALU_BLT) ||
           (c == ALU_BGE) || (c == ALU_BLTU) || (c == ALU_BGEU);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative 1-bit-per-cycle shifter; direction and fill mode are latched on load.
module alu_serial_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               dir_right,
  input  logic               arith,
  input  logic [XLEN-1:0]    load_val,
  input  logic [SHAMT_W-1:0] load_cnt,
  output logic [XLEN-1:0]    acc_nxt,
  output logic               done
);

  logic [XLEN-1:0]    acc;
  logic [SHAMT_W-1:0] cnt;
  logic               right_q;
  logic               arith_q;

  assign acc_nxt = right_q ? {arith_q & acc[XLEN-1], acc[XLEN-1:1]}
                           : {acc[XLEN-2:0], 1'b0};

  // Asserted in the cycle whose step produces the final value on acc_nxt.
  assign done = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      acc     <= load_val;
      cnt     <= load_cnt;
      right_q <= dir_right;
      arith_q <= arith;
    end else if (step && cnt != '0) begin
      acc <= acc_nxt;
      cnt <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare/branch/link ops, serial shifts,
// valid/ready on both sides with back-to-back issue from DONE.
module alu_exec
  import alu_pkg::*;
#(
  parameter  int XLEN    = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      aluc_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            branch_taken_o,
  output logic            illegal_o,
  output logic            busy_o
);

  state_e             state_q, state_d;
  logic               accept, go_shift, load, step, sh_done;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    sh_nxt;
  logic [XLEN-1:0]    c_res;
  logic               c_taken, c_ill;

  assign in_ready_o = !rst_i && (state_q == IDLE || (state_q == DONE && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;
  assign shamt      = op_b_i[SHAMT_W-1:0];
  assign go_shift   = is_shift(aluc_i) && (shamt != '0);
  assign busy_o     = (state_q == SHIFT);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // accept only ever fires from IDLE or DONE, so it takes priority over the per-state moves.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    if (accept) begin
      state_d = go_shift ? SHIFT : DONE;
      load    = go_shift;
    end else begin
      case (state_q)
        SHIFT: begin
          step = 1'b1;
          if (sh_done) state_d = DONE;
        end
        DONE:    if (out_ready_i) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  alu_serial_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (load),
    .step      (step),
    .dir_right (aluc_i != ALU_SLL),
    .arith     (aluc_i == ALU_SRA),
    .load_val  (op_a_i),
    .load_cnt  (shamt),
    .acc_nxt   (sh_nxt),
    .done      (sh_done)
  );

  // Shift codes only land here with shamt == 0, where the result is op_a unchanged.
  always_comb begin
    c_res   = '0;
    c_taken = 1'b0;
    c_ill   = 1'b0;
    case (aluc_e'(aluc_i))
      ALU_ADD:  c_res = op_a_i + op_b_i;
      ALU_SUB:  c_res = op_a_i - op_b_i;
      ALU_SLL, ALU_SRL, ALU_SRA: c_res = op_a_i;
      ALU_SLT:  c_res = XLEN'($signed(op_a_i) < $signed(op_b_i));
      ALU_SLTU: c_res = XLEN'(op_a_i < op_b_i);
      ALU_XOR:  c_res = op_a_i ^ op_b_i;
      ALU_OR:   c_res = op_a_i | op_b_i;
      ALU_AND:  c_res = op_a_i & op_b_i;
      ALU_BEQ:  c_taken = (op_a_i == op_b_i);
      ALU_BNE:  c_taken = (op_a_i != op_b_i);
      ALU_BLT:  c_taken = ($signed(op_a_i) <  $signed(op_b_i));
      ALU_BGE:  c_taken = ($signed(op_a_i) >= $signed(op_b_i));
      ALU_BLTU: c_taken = (op_a_i <  op_b_i);
      ALU_BGEU: c_taken = (op_a_i >= op_b_i);
      ALU_JAL: begin
        c_res   = op_a_i + XLEN'(4);
        c_taken = 1'b1;
      end
      default:  c_ill = 1'b1;
    endcase
    if (is_branch(aluc_i)) c_res = XLEN'(c_taken);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o    <= 1'b0;
      result_o       <= '0;
      branch_taken_o <= 1'b0;
      illegal_o      <= 1'b0;
    end else if (accept) begin
      out_valid_o    <= !go_shift;
      branch_taken_o <= go_shift ? 1'b0 : c_taken;
      illegal_o      <= go_shift ? 1'b0 : c_ill;
      if (!go_shift) result_o <= c_res;
    end else if (state_q == SHIFT && sh_done) begin
      out_valid_o <= 1'b1;
      result_o    <= sh_nxt;
    end else if (state_q == DONE && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU that directly consumes the 5-bit ALU control code produced by the ALU-control decoder, plus two operands.
- Add, sub, logic, compare, branch-compare and link ops complete in one cycle.
- Shifts use an iterative 1-bit-per-cycle shifter to save area.
- Valid/ready handshakes on both sides let the pipeline stall around multi-cycle shifts.

Parameters:
- XLEN, 32, datapath width.
- SHAMT_W, $clog2(XLEN), shift-amount width; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  operation presented.
- in_ready_o  out  1  block can accept an operation this cycle.
- aluc_i  in  5  ALU control code.
- op_a_i  in  XLEN  operand A (rs1 or PC).
- op_b_i  in  XLEN  operand B (rs2 or immediate).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer takes the result.
- result_o  out  XLEN  result.
- branch_taken_o  out  1  branch/jump taken.
- illegal_o  out  1  unsupported aluc code.
- busy_o  out  1  shift in progress.

Behaviour:
- Reset: one clock, rst_i synchronous active-high. On reset:
  - state=IDLE.
  - out_valid_o=0, result_o=0, branch_taken_o=0, illegal_o=0, busy_o=0.
  - in_ready_o=0 while rst_i is high.
- Reset mid-shift abandons the operation with no output.
- Accept: occurs when in_valid_i && in_ready_o. aluc_i, op_a_i and op_b_i are captured at accept; later changes are ignored.
- in_ready_o:
  - 1 in IDLE.
  - Equal to out_ready_i in DONE.
  - 0 in SHIFT.
- FSM IDLE -> DONE, for non-shift ops, or for a shift with shamt=0:
  - Result is registered at accept.
  - out_valid_o is high in cycle t+1.
- FSM IDLE -> SHIFT, for a shift with shamt=n>0:
  - Load acc=op_a_i, cnt=n.
  - Each SHIFT cycle shifts acc by 1 and decrements cnt.
  - When cnt reaches 0, go to DONE.
  - out_valid_o is high in cycle t+1+n; busy_o=1 throughout SHIFT.
- FSM DONE:
  - result_o, branch_taken_o and illegal_o are held stable until out_ready_i.
  - On out_ready_i with a simultaneous accept, process the new op exactly as from IDLE (back-to-back, no bubble).
  - On out_ready_i alone, go to IDLE and clear out_valid_o.
- Codes and results:
  - 00000 add: a+b.
  - 01000 sub: a-b.
  - 00001 sll.
  - 00101 srl: zero fill.
  - 01101 sra: sign fill.
  - 00010 slt: signed, result 0 or 1.
  - 00011 sltu: unsigned, result 0 or 1.
  - 00100 xor.
  - 00110 or.
  - 00111 and.
- Width rules: add/sub wrap modulo 2^XLEN. Shift amount is op_b_i[SHAMT_W-1:0]; upper bits are ignored.
- Branch codes (10000 beq, 10001 bne, 10100 blt, 10101 bge, 10110 bltu, 10111 bgeu):
  - branch_taken_o = compare outcome.
  - result_o = zero-extended taken bit.
- 11111 jal/jalr: result_o = op_a_i+4, branch_taken_o=1.
- Any other code: result_o=0, branch_taken_o=0, illegal_o=1, latency 1; no hang.
- branch_taken_o and illegal_o are 0 for all ops where not stated.

Decomposition:
- alu_pkg holds:
  - typedef enum logic[4:0] aluc_e with all codes above.
  - state enum {IDLE, SHIFT, DONE}.
  - Helper predicates is_shift and is_branch.
- One sub-module, alu_serial_shifter, contains:
  - acc register and cnt register.
  - load/step inputs, direction/arith select, done flag.
- alu_exec contains the FSM, the combinational single-cycle ops and the output registers.

Test Plan:
- add a=0xFFFFFFFF b=1, out_ready_i=1 -> result 0x00000000, out_valid in cycle t+1, in_ready back high.
- sra a=0x80000000 b=0x24 (shamt 4) -> busy 4 cycles, result 0xF8000000 in cycle t+5; sll with b=0 -> 0 extra cycles, result=a.
- blt a=0xFFFFFFFE (-2) b=1 -> branch_taken 1, result 1; bltu same operands -> taken 0, result 0.
- DONE held with out_ready_i=0 for 3 cycles while op_a_i/op_b_i toggle -> result_o stable; then out_ready_i=1 with in_valid_i=1 (xor 0xF0F0, 0x0FF0) -> new result 0xFF00 in the next cycle, no bubble.
- rst_i asserted in the 3rd cycle of a shamt=10 srl -> next cycle IDLE, out_valid 0, busy 0, result 0; subsequent op executes normally.
- aluc_i=01111 -> illegal_o 1, result 0, out_valid after 1 cycle; jal a=0x100 -> result 0x104, branch_taken 1.
